iq_txd_serializer: RTL and testbench
====================================

Name: iq_txd_serializer

Overview:
- Transmit-side counterpart of the IQ receive path: accepts 32-bit AXI-Stream words and serializes each word onto the 2-bit IQ_TXD symbol bus, MSB symbol first.
- Runs in the AXIS clock domain. Symbol timing comes from a one-cycle enable strobe, sym_ce, generated upstream from the 32 MHz IQ clock.
- Frames are delimited by tlast; a fixed inter-frame gap of idle symbols follows each frame.

Parameters:
- DATA_WIDTH, 32, stream word width; must be even. 16 symbols per word at the default.
- IDLE_SYM, 2'b00, symbol driven when no data is being sent.
- GAP_SYMS, 4, number of idle symbols inserted after a tlast word; 0 is legal.
- PREAMBLE, 32'hA5A5_A5A5, preamble word; used only with IQ_TXD_PREAMBLE_EN.

Ports:
- s00_axis_aclk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- s00_axis_tdata  in  DATA_WIDTH  word to transmit.
- s00_axis_tstrb  in  DATA_WIDTH/8  ignored; all byte lanes are treated as valid.
- s00_axis_tlast  in  1  last word of a frame.
- s00_axis_tvalid  in  1  upstream word valid.
- s00_axis_tready  out  1  holding register empty.
- sym_ce  in  1  symbol strobe; one symbol is emitted per high cycle.
- IQ_TXD  out  2  serial IQ symbol output, registered.
- iq_active  out  1  high while IQ_TXD carries a data or preamble symbol.
- underrun  out  1  sticky mid-frame starvation flag.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (synchronous, active-high): on the first clock with reset high:
  - IQ_TXD=IDLE_SYM, iq_active=0, underrun=0.
  - Holding register empties; state=IDLE; counters are zeroed.
  - tready=0 while reset is high.
- Reset mid-word aborts the word and discards the held word.
- Input side:
  - tready = ~hold_vld & ~reset. No combinational path from tvalid.
  - A transfer (tvalid & tready) captures tdata and tlast into the holding register and sets hold_vld.
  - tvalid high with tready low: the upstream holds its data; no loss and no duplication.
- Output timing:
  - IQ_TXD, iq_active and state change only on cycles with sym_ce=1.
  - sym_ce held continuously high is legal and gives one symbol per clock.
- IDLE state:
  - On sym_ce with hold_vld=0: emit IDLE_SYM, iq_active=0.
  - On sym_ce with hold_vld=1: load the shifter from the holding register, emit tdata[31:30], sym_cnt=1, clear hold_vld, go to SHIFT.
  - The upstream can refill the holding register from the next cycle.
- SHIFT state, on sym_ce:
  - sym_cnt<16: emit the next symbol (shifter bits [31:30] after a shift left by 2), then sym_cnt++.
  - sym_cnt==16, word had tlast: emit IDLE_SYM and go to GAP (gap_cnt=1). If GAP_SYMS=0, go directly to IDLE instead, applying the IDLE load rule on this same strobe.
  - sym_cnt==16, no tlast, hold_vld=1: load the next word seamlessly, with no idle symbol between words.
  - sym_cnt==16, no tlast, hold_vld=0: underrun. Set underrun=1, emit IDLE_SYM, go to IDLE. The remainder of the frame is sent as a new frame when data arrives.
- GAP state:
  - Emit IDLE_SYM until GAP_SYMS idle symbols have been sent, then go to IDLE.
  - Data arriving during GAP waits in the holding register.
- underrun flag:
  - Cleared by underrun_clr.
  - Set and clear in the same cycle: set wins.
- Latency: a word accepted at least one cycle before a sym_ce strobe in IDLE appears on IQ_TXD the clock after that strobe.

Optional Feature:
- Macro: IQ_TXD_PREAMBLE_EN.
- Defined:
  - On the IDLE->first-word transition, enter a PRE state instead of SHIFT.
  - PRE emits PREAMBLE (16 symbols, MSB first, iq_active=1), then loads the held word into SHIFT with no idle symbol between.
  - Preamble is inserted only at the start of a frame, i.e. after IDLE. It is not inserted between seamless words.
  - Reset in PRE returns to IDLE.
- Not defined: no PRE state; PREAMBLE is unused; behaviour is exactly as above.

Test Plan:
1. One word 32'h1B1B_1B1B, tlast=1, sym_ce every 6 clocks -> IQ_TXD shows 0,1,2,3 four times with iq_active=1 for 16 symbols, then 4 IDLE_SYM symbols, then IDLE.
2. Three-word frame, sym_ce tied high, tvalid always high -> 48 contiguous data symbols with no idle symbol inserted; exactly 3 transfers; underrun stays 0.
3. Single word without tlast, no follow-up word -> after 16 data symbols, IQ_TXD=00 and underrun=1. underrun_clr pulse clears it; underrun_clr asserted on the setting cycle is ignored.
4. Reset asserted for one clock at symbol 7 of a word -> next clock IQ_TXD=00, iq_active=0, tready=0. After release, tready=1 and a new word starts at its bits [31:30].
5. tvalid held high with a second word while the holding register is full -> tready=0 until the first word is loaded into the shifter; second word transmitted exactly once, unaltered.
6. IQ_TXD_PREAMBLE_EN defined, one word 32'h0000_0000 with tlast -> 2,2,1,1 repeated 4 times, then 16 zero data symbols with iq_active=1, then the gap.

Source files
------------

// File: rtl/iq_txd_serializer_if.sv
// iq_txd_serializer_if: AXI-Stream bundle feeding the IQ TXD serializer.
interface iq_txd_serializer_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (output tdata, tstrb, tlast, tvalid, input tready);
  modport slave (input tdata, tstrb, tlast, tvalid, output tready);
endinterface

// File: rtl/iq_txd_serializer.sv
// iq_txd_serializer: serializes AXI-Stream words onto the 2-bit IQ_TXD bus, MSB symbol first.
// Define IQ_TXD_PREAMBLE_EN to prefix every frame with the PREAMBLE word.
module iq_txd_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter logic [1:0] IDLE_SYM = 2'b00,
  parameter int GAP_SYMS = 4,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE = 32'hA5A5_A5A5
) (
  input  logic s00_axis_aclk,
  input  logic reset,
  iq_txd_serializer_if.slave s00_axis,
  input  logic sym_ce,
  output logic [1:0] IQ_TXD,
  output logic iq_active,
  output logic underrun,
  input  logic underrun_clr
);
  localparam int SYMS = DATA_WIDTH / 2;
  localparam int CW = $clog2(SYMS + 1);
  localparam int GW = $clog2(GAP_SYMS + 2);
  localparam logic [CW-1:0] SYMS_L = CW'(SYMS);
  localparam logic [GW-1:0] GAP_L = GW'(GAP_SYMS);
  typedef enum logic [1:0] {
    IDLE, SHIFT, GAP
`ifdef IQ_TXD_PREAMBLE_EN
    , PRE
`endif
  } state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] hold_data, shifter, shifter_n;
  logic hold_last, hold_vld, cur_last, cur_last_n;
  logic take, start, set_ur, xfer, active_n;
  logic [CW-1:0] sym_cnt, sym_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [1:0] txd_n;
  assign s00_axis.tready = ~hold_vld & ~reset;
  assign xfer = s00_axis.tvalid & s00_axis.tready;
  always_comb begin
    state_n = state;
    shifter_n = shifter;
    cur_last_n = cur_last;
    sym_cnt_n = sym_cnt;
    gap_cnt_n = gap_cnt;
    txd_n = IQ_TXD;
    active_n = iq_active;
    take = 1'b0;
    start = 1'b0;
    set_ur = 1'b0;
    if (sym_ce) begin
      txd_n = IDLE_SYM;
      active_n = 1'b0;
      case (state)
        IDLE: start = 1'b1;
        GAP: if (gap_cnt >= GAP_L) start = 1'b1; else gap_cnt_n = gap_cnt + 1'b1;
        default:
          if (sym_cnt != SYMS_L) begin
            shifter_n = shifter << 2;
            txd_n = shifter[DATA_WIDTH-3 -: 2];
            active_n = 1'b1;
            sym_cnt_n = sym_cnt + 1'b1;
          end else if (state != SHIFT) take = 1'b1;
          else if (cur_last) begin
            if (GAP_SYMS == 0) start = 1'b1;
            else begin
              state_n = GAP;
              gap_cnt_n = GW'(1);
            end
          end else if (hold_vld) take = 1'b1;
          else begin
            set_ur = 1'b1;
            state_n = IDLE;
          end
      endcase
      // A frame start either opens with the preamble or goes straight to the held word
      if (start) begin
        state_n = IDLE;
        if (hold_vld) begin
`ifdef IQ_TXD_PREAMBLE_EN
          state_n = PRE;
          shifter_n = PREAMBLE;
          txd_n = PREAMBLE[DATA_WIDTH-1 -: 2];
          active_n = 1'b1;
          sym_cnt_n = CW'(1);
`else
          take = 1'b1;
`endif
        end
      end
      if (take) begin
        state_n = SHIFT;
        shifter_n = hold_data;
        cur_last_n = hold_last;
        txd_n = hold_data[DATA_WIDTH-1 -: 2];
        active_n = 1'b1;
        sym_cnt_n = CW'(1);
      end
    end
  end
  always_ff @(posedge s00_axis_aclk) begin
    if (reset) begin
      state <= IDLE;
      shifter <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_vld <= 1'b0;
      cur_last <= 1'b0;
      sym_cnt <= '0;
      gap_cnt <= '0;
      IQ_TXD <= IDLE_SYM;
      iq_active <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      shifter <= shifter_n;
      cur_last <= cur_last_n;
      sym_cnt <= sym_cnt_n;
      gap_cnt <= gap_cnt_n;
      IQ_TXD <= txd_n;
      iq_active <= active_n;
      hold_vld <= (hold_vld & ~take) | xfer;
      if (xfer) begin
        hold_data <= s00_axis.tdata;
        hold_last <= s00_axis.tlast;
      end
      underrun <= set_ur | (underrun & ~underrun_clr);
    end
  end
endmodule

// File: tb/tb_iq_txd_serializer.sv
// tb_iq_txd_serializer: directed and randomized checks of the IQ TXD serializer against a symbol-stream model.
module tb_iq_txd_serializer;
  localparam int GAP = 4;
  localparam logic [31:0] PRE_W = 32'hA5A5_A5A5;
`ifdef IQ_TXD_PREAMBLE_EN
  localparam int PRE_N = 16;
`else
  localparam int PRE_N = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sym_ce = 1'b0;
  logic underrun_clr = 1'b0;
  logic [1:0] iq_txd;
  logic iq_active, underrun;
  int checks = 0, errors = 0, xfers = 0, ce_period = -1;
  logic [2:0] mon_q[$];
  logic [2:0] exp_q[$];
  iq_txd_serializer_if #(.DATA_WIDTH(32)) axis ();
  iq_txd_serializer dut (
    .s00_axis_aclk(clk), .reset(reset), .s00_axis(axis), .sym_ce(sym_ce),
    .IQ_TXD(iq_txd), .iq_active(iq_active), .underrun(underrun), .underrun_clr(underrun_clr)
  );
  always #5 clk = ~clk;
  initial begin : ce_drv
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ce_period == 0) sym_ce = 1'b0;
      else if (ce_period == 1) sym_ce = 1'b1;
      else if (ce_period > 1) begin
        cnt = (cnt + 1) % ce_period;
        sym_ce = (cnt == 0);
      end else if (ce_period == -2) sym_ce = ($urandom_range(0, 2) == 0);
    end
  end
  // Record the symbol emitted by every strobe the DUT actually sampled
  initial begin : mon
    logic c;
    forever begin
      @(posedge clk);
      c = sym_ce & ~reset;
      @(negedge clk);
      if (c) mon_q.push_back({iq_active, iq_txd});
      if (axis.tvalid && axis.tready) xfers++;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic strobe(input logic clr);
    sym_ce = 1'b1;
    underrun_clr = clr;
    tick(1);
    sym_ce = 1'b0;
    underrun_clr = 1'b0;
  endtask
  task automatic set_ce(input int p);
    ce_period = p;
    if (p < 0) sym_ce = 1'b0;
  endtask
  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    axis.tvalid = 1'b1;
    axis.tdata = d;
    axis.tlast = l;
    @(negedge clk);
    while (!axis.tready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", n < 5000, 1);
    tick(1);
    axis.tvalid = 1'b0;
  endtask
  task automatic add_word(input logic [31:0] d);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, d[31-2*i -: 2]});
  endtask
  task automatic add_pre();
    if (PRE_N != 0) add_word(PRE_W);
  endtask
  task automatic add_gap();
    repeat (GAP) exp_q.push_back(3'b000);
  endtask
  task automatic compare(input string tag);
    int k = 0, act = 0;
    while (k < mon_q.size() && mon_q[k][2] == 1'b0) k++;
    foreach (exp_q[i]) chk(tag, (k + i < mon_q.size()) ? mon_q[k + i] : 3'bxxx, exp_q[i]);
    for (int i = k + exp_q.size(); i < mon_q.size(); i++) act += int'(mon_q[i][2]);
    chk({tag, "_tail"}, act, 0);
    mon_q.delete();
    exp_q.delete();
  endtask
  initial begin
    logic [31:0] d;
    int nw;
    axis.tvalid = 1'b0;
    axis.tdata = '0;
    axis.tlast = 1'b0;
    axis.tstrb = '1;
    tick(3);
    @(negedge clk);
    chk("rst_txd", iq_txd, 0);
    chk("rst_active", iq_active, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_tready", axis.tready, 0);
    tick(1);
    reset = 1'b0;
    tick(2);
    mon_q.delete();
    // single word, slow strobe
    set_ce(6);
    push(32'h1B1B_1B1B, 1'b1);
    add_pre();
    add_word(32'h1B1B_1B1B);
    add_gap();
    tick((PRE_N + 16 + GAP + 3) * 6);
    compare("one_word");
    // three contiguous words, strobe tied high
    set_ce(1);
    xfers = 0;
    push(32'h1234_5678, 1'b0);
    push(32'h9ABC_DEF0, 1'b0);
    push(32'h0F0F_3C3C, 1'b1);
    add_pre();
    add_word(32'h1234_5678);
    add_word(32'h9ABC_DEF0);
    add_word(32'h0F0F_3C3C);
    add_gap();
    tick(PRE_N + 48 + GAP + 10);
    chk("three_xfers", xfers, 3);
    chk("three_underrun", underrun, 0);
    compare("three_words");
    // all-zero word; with the preamble enabled this shows 2,2,1,1 first
    push(32'h0000_0000, 1'b1);
    add_pre();
    add_word(32'h0000_0000);
    add_gap();
    tick(PRE_N + 16 + GAP + 10);
    compare("zero_word");
    // underrun: word without tlast and no follower
    set_ce(-1);
    tick(2);
    mon_q.delete();
    push(32'hC3A5_5A3C, 1'b0);
    repeat (PRE_N + 16) strobe(1'b0);
    @(negedge clk);
    chk("ur_before", underrun, 0);
    tick(1);
    strobe(1'b1);
    @(negedge clk);
    chk("ur_set_wins", underrun, 1);
    chk("ur_txd", iq_txd, 0);
    chk("ur_active", iq_active, 0);
    tick(3);
    @(negedge clk);
    chk("ur_sticky", underrun, 1);
    tick(1);
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    @(negedge clk);
    chk("ur_cleared", underrun, 0);
    tick(1);
    add_pre();
    add_word(32'hC3A5_5A3C);
    compare("ur_stream");
    // reset at symbol 7, with a second word held
    push(32'hDEAD_BEEF, 1'b1);
    repeat (PRE_N + 7) strobe(1'b0);
    push(32'h7777_7777, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tready_low", axis.tready, 0);
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_txd", iq_txd, 0);
    chk("midrst_active", iq_active, 0);
    chk("midrst_tready_high", axis.tready, 1);
    tick(1);
    mon_q.delete();
    push(32'h4B2D_E1F8, 1'b1);
    repeat (PRE_N + 16 + GAP + 2) strobe(1'b0);
    add_pre();
    add_word(32'h4B2D_E1F8);
    add_gap();
    compare("after_rst");
    // backpressure while the holding register is full
    xfers = 0;
    push(32'h1357_9BDF, 1'b1);
    axis.tvalid = 1'b1;
    axis.tdata = 32'h2468_ACE0;
    axis.tlast = 1'b1;
    tick(3);
    @(negedge clk);
    chk("bp_tready", axis.tready, 0);
    chk("bp_xfers", xfers, 1);
    tick(1);
    set_ce(1);
    push(32'h2468_ACE0, 1'b1);
    tick(2 * (PRE_N + 16 + GAP) + 10);
    chk("bp_xfers_total", xfers, 2);
    add_pre();
    add_word(32'h1357_9BDF);
    add_gap();
    add_pre();
    add_word(32'h2468_ACE0);
    add_gap();
    compare("backpressure");
    // randomized frames under random and continuous strobes
    for (int r = 0; r < 2; r++) begin
      set_ce(r == 0 ? -2 : 1);
      for (int f = 0; f < 6; f++) begin
        nw = $urandom_range(1, 3);
        add_pre();
        for (int w = 0; w < nw; w++) begin
          d = $urandom;
          push(d, w == nw - 1);
          add_word(d);
        end
        add_gap();
      end
      tick(700);
      chk("rand_underrun", underrun, 0);
      compare(r == 0 ? "rand_ce" : "rand_full");
    end
    set_ce(-1);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
